panel_ctrl: RTL and testbench

PANEL_CTRL -- requirements
Module: panel_ctrl

---
 rtl/panel_pkg.sv | 28 ++
 rtl/panel_debounce.sv | 44 ++++
 rtl/panel_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_panel_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// Shared program codes and panel state encoding for the washer control panel.
// The washer FSM imports the same program codes from here.
package panel_pkg;

    localparam logic [2:0] COLD_WASH   = 3'b000;
    localparam logic [2:0] HOT_WASH    = 3'b001;
    localparam logic [2:0] RINSING_DRY = 3'b010;
    localparam logic [2:0] ONLY_DRY    = 3'b011;

    typedef enum logic [1:0] {
        ST_SELECT  = 2'b00,
        ST_RUNNING = 2'b01,
        ST_UNLOCK  = 2'b10
    } panel_state_e;

    // Cycles through the four valid programs; unused codes fall back to COLD_WASH.
    function automatic logic [2:0] next_program(input logic [2:0] sel);
        logic [2:0] nxt;
        case (sel)
            COLD_WASH:   nxt = HOT_WASH;
            HOT_WASH:    nxt = RINSING_DRY;
            RINSING_DRY: nxt = ONLY_DRY;
            default:     nxt = COLD_WASH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/panel_debounce.sv
// Single-bit debouncer: output follows the raw input once it has disagreed
// with the output for DEBOUNCE_CYCLES consecutive cycles.
module panel_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       lvl_q, lvl_d;

    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (clr) begin
            lvl_d = 1'b0;
        end else if (din != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d = din;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign dout = lvl_q;

endmodule

// File: rtl/panel_ctrl.sv
// Washer front-panel controller: debounced inputs, program selection, start/lock FSM.
// Optional feature: define PANEL_BEEP_EN to add the beep output.
module panel_ctrl
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int UNLOCK_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power,
    input  logic       start_btn,
    input  logic       prog_btn,
    input  logic       door_sw,
    input  logic       soap_sw,
    input  logic       program_done,
    output logic [2:0] program_selection,
    output logic       start,
    output logic       doorclosed,
    output logic       soap,
    output logic       door_lock,
    output logic       busy,
    output logic       door_warning
`ifdef PANEL_BEEP_EN
    ,
    output logic       beep
`endif
);

    localparam logic [15:0] UNLOCK_LAST = 16'(UNLOCK_CYCLES - 1);

    logic start_db, prog_db, door_db, soap_db;
    logic start_evt, prog_evt;

    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk(clk), .rst(rst), .clr(~power), .din(start_btn), .dout(start_db));
    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prog (
        .clk(clk), .rst(rst), .clr(~power), .din(prog_btn), .dout(prog_db));
    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_door (
        .clk(clk), .rst(rst), .clr(~power), .din(door_sw), .dout(door_db));
    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_soap (
        .clk(clk), .rst(rst), .clr(~power), .din(soap_sw), .dout(soap_db));

    panel_state_e state_q, state_d;
    logic [2:0]   sel_q, sel_d;
    logic [15:0]  ucnt_q, ucnt_d;
    logic         start_q, start_d;
    logic         lock_q, lock_d;
    logic         busy_q, busy_d;
    logic         warn_q, warn_d;
    logic         start_dly_q, start_dly_d;
    logic         prog_dly_q, prog_dly_d;

    // Press events fire on the cycle after the debounced level rises.
    assign start_evt = start_db & ~start_dly_q;
    assign prog_evt  = prog_db & ~prog_dly_q;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ucnt_d      = ucnt_q;
        start_d     = 1'b0;
        lock_d      = lock_q;
        busy_d      = busy_q;
        warn_d      = 1'b0;
        start_dly_d = start_db;
        prog_dly_d  = prog_db;
        if (!power) begin
            state_d     = ST_SELECT;
            sel_d       = COLD_WASH;
            ucnt_d      = '0;
            lock_d      = 1'b0;
            busy_d      = 1'b0;
            start_dly_d = 1'b0;
            prog_dly_d  = 1'b0;
        end else begin
            case (state_q)
                ST_SELECT: begin
                    if (start_evt) begin
                        if (door_db) begin
                            start_d = 1'b1;
                            lock_d  = 1'b1;
                            busy_d  = 1'b1;
                            state_d = ST_RUNNING;
                        end else begin
                            warn_d = 1'b1;
                        end
                    end else if (prog_evt) begin
                        sel_d = next_program(sel_q);
                    end
                end
                ST_RUNNING: begin
                    lock_d = 1'b1;
                    busy_d = 1'b1;
                    if (program_done) begin
                        busy_d  = 1'b0;
                        ucnt_d  = '0;
                        state_d = ST_UNLOCK;
                    end
                end
                ST_UNLOCK: begin
                    busy_d = 1'b0;
                    if (ucnt_q == UNLOCK_LAST) begin
                        lock_d  = 1'b0;
                        ucnt_d  = '0;
                        state_d = ST_SELECT;
                    end else begin
                        ucnt_d = ucnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_SELECT;
                    lock_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SELECT;
            sel_q       <= COLD_WASH;
            ucnt_q      <= '0;
            start_q     <= 1'b0;
            lock_q      <= 1'b0;
            busy_q      <= 1'b0;
            warn_q      <= 1'b0;
            start_dly_q <= 1'b0;
            prog_dly_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ucnt_q      <= ucnt_d;
            start_q     <= start_d;
            lock_q      <= lock_d;
            busy_q      <= busy_d;
            warn_q      <= warn_d;
            start_dly_q <= start_dly_d;
            prog_dly_q  <= prog_dly_d;
        end
    end

`ifdef PANEL_BEEP_EN
    logic       beep_q, beep_d;
    logic [1:0] beep_cnt_q, beep_cnt_d;

    // Three-cycle chirp on entering UNLOCK, single chirp with each door warning.
    always_comb begin
        beep_d     = 1'b0;
        beep_cnt_d = 2'd0;
        if (power) begin
            if (beep_cnt_q != 2'd0) begin
                beep_d     = 1'b1;
                beep_cnt_d = beep_cnt_q - 2'd1;
            end
            if (state_d == ST_UNLOCK && state_q != ST_UNLOCK) begin
                beep_d     = 1'b1;
                beep_cnt_d = 2'd2;
            end
            if (warn_d) begin
                beep_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_q     <= 1'b0;
            beep_cnt_q <= 2'd0;
        end else begin
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign beep = beep_q;
`endif

    assign program_selection = sel_q;
    assign start             = start_q;
    assign doorclosed        = door_db;
    assign soap              = soap_db;
    assign door_lock         = lock_q;
    assign busy              = busy_q;
    assign door_warning      = warn_q;

endmodule

// File: tb/tb_panel_ctrl.sv
// Directed bench for panel_ctrl with DEBOUNCE_CYCLES=4, UNLOCK_CYCLES=8.
module tb_panel_ctrl;

    logic       clk;
    logic       rst;
    logic       power;
    logic       start_btn;
    logic       prog_btn;
    logic       door_sw;
    logic       soap_sw;
    logic       program_done;
    logic [2:0] program_selection;
    logic       start;
    logic       doorclosed;
    logic       soap;
    logic       door_lock;
    logic       busy;
    logic       door_warning;

    int total = 0;
    int bad   = 0;

    panel_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .UNLOCK_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .power(power),
        .start_btn(start_btn),
        .prog_btn(prog_btn),
        .door_sw(door_sw),
        .soap_sw(soap_sw),
        .program_done(program_done),
        .program_selection(program_selection),
        .start(start),
        .doorclosed(doorclosed),
        .soap(soap),
        .door_lock(door_lock),
        .busy(busy),
        .door_warning(door_warning)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic press_prog();
        prog_btn = 1'b1;
        repeat (6) tick();
        prog_btn = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        rst = 1'b1; power = 1'b1; start_btn = 1'b0; prog_btn = 1'b0;
        door_sw = 1'b0; soap_sw = 1'b0; program_done = 1'b0;
        tick(); tick();
        chk3("rst_sel", program_selection, 3'b000);
        chk1("rst_start", start, 1'b0);
        chk1("rst_lock", door_lock, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_warn", door_warning, 1'b0);
        chk1("rst_door", doorclosed, 1'b0);
        chk1("rst_soap", soap, 1'b0);

        rst = 1'b0; door_sw = 1'b1;
        repeat (3) tick();
        chk1("door_db_3", doorclosed, 1'b0);
        tick();
        chk1("door_db_4", doorclosed, 1'b1);

        // Short glitch must be filtered.
        prog_btn = 1'b1;
        repeat (3) tick();
        prog_btn = 1'b0;
        repeat (6) tick();
        chk3("prog_glitch", program_selection, 3'b000);

        prog_btn = 1'b1;
        repeat (4) tick();
        chk3("prog_lat4", program_selection, 3'b000);
        tick();
        chk3("prog_lat5", program_selection, 3'b001);
        tick();
        prog_btn = 1'b0;
        repeat (6) tick();
        press_prog();
        chk3("prog_twice", program_selection, 3'b010);

        // Start with door closed.
        start_btn = 1'b1;
        repeat (4) tick();
        chk1("start_lat4", start, 1'b0);
        tick();
        chk1("start_lat5", start, 1'b1);
        chk1("start_lock", door_lock, 1'b1);
        chk1("start_busy", busy, 1'b1);
        tick();
        chk1("start_one_cycle", start, 1'b0);
        chk1("run_lock", door_lock, 1'b1);
        chk1("run_busy", busy, 1'b1);
        start_btn = 1'b0;
        repeat (6) tick();

        press_prog();
        chk3("run_sel_hold", program_selection, 3'b010);
        start_btn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk1("run_start_ignored", start, 1'b0);
        end
        start_btn = 1'b0;
        repeat (6) tick();
        chk1("run_busy_still", busy, 1'b1);

        program_done = 1'b1;
        tick();
        program_done = 1'b0;
        chk1("done_busy", busy, 1'b0);
        chk1("done_lock", door_lock, 1'b1);
        repeat (7) tick();
        chk1("unlock_hold7", door_lock, 1'b1);
        tick();
        chk1("unlock_rel8", door_lock, 1'b0);
        chk3("unlock_sel", program_selection, 3'b010);

        // Start refused with door open.
        door_sw = 1'b0;
        repeat (4) tick();
        chk1("door_open", doorclosed, 1'b0);
        start_btn = 1'b1;
        repeat (4) tick();
        chk1("warn_lat4", door_warning, 1'b0);
        tick();
        chk1("warn_pulse", door_warning, 1'b1);
        chk1("warn_no_start", start, 1'b0);
        tick();
        chk1("warn_one_cycle", door_warning, 1'b0);
        chk1("warn_no_start2", start, 1'b0);
        start_btn = 1'b0;
        repeat (6) tick();
        chk1("warn_busy", busy, 1'b0);
        chk1("warn_lock", door_lock, 1'b0);

        press_prog();
        chk3("sel_011", program_selection, 3'b011);
        press_prog();
        chk3("sel_wrap", program_selection, 3'b000);
        press_prog();
        chk3("sel_001", program_selection, 3'b001);

        // Asynchronous reset while running.
        door_sw = 1'b1;
        repeat (4) tick();
        start_btn = 1'b1;
        repeat (5) tick();
        chk1("run2_busy", busy, 1'b1);
        start_btn = 1'b0;
        repeat (3) tick();
        chk1("run2_lock", door_lock, 1'b1);
        #3;
        rst = 1'b1;
        #2;
        chk1("arst_lock", door_lock, 1'b0);
        chk3("arst_sel", program_selection, 3'b000);
        chk1("arst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;

        // Power drop while running.
        soap_sw = 1'b1;
        repeat (4) tick();
        chk1("soap_db", soap, 1'b1);
        press_prog();
        chk3("pwr_sel_pre", program_selection, 3'b001);
        start_btn = 1'b1;
        repeat (5) tick();
        chk1("run3_busy", busy, 1'b1);
        start_btn = 1'b0;
        repeat (2) tick();
        chk1("run3_door", doorclosed, 1'b1);
        chk1("run3_soap", soap, 1'b1);
        power = 1'b0;
        tick();
        chk3("pwr_sel", program_selection, 3'b000);
        chk1("pwr_lock", door_lock, 1'b0);
        chk1("pwr_busy", busy, 1'b0);
        chk1("pwr_start", start, 1'b0);
        chk1("pwr_warn", door_warning, 1'b0);
        chk1("pwr_door", doorclosed, 1'b0);
        chk1("pwr_soap", soap, 1'b0);
        power = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
